// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences the shared ALU
// one operation per state and drives every datapath select and write enable.
module multicycle_ctrl #(
   parameter int         STATE_W  = 4,
   parameter logic [5:0] RTYPE_OP = 6'b000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               iord,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [2:0]         alu_control,
   output logic [1:0]         pc_src,
   output logic               pc_en,
   output logic               illegal_instr,
   output logic               retire,
   output logic [STATE_W-1:0] state
);

   // state   | meaning
   // FETCH   | read instruction at PC, PC <= PC + 4
   // DECODE  | precompute branch target, dispatch on op
   // MEMADR  | address = A + sign-extended immediate
   // MEMRD   | load access, held until mem_ready
   // MEMWB   | write load data to rt
   // MEMWR   | store access, held until mem_ready
   // EXEC    | R-type ALU operation
   // ALUWB   | write ALU result to rd
   // BRANCH  | compare A - B, conditionally load branch target
   // ADDIEX  | A + sign-extended immediate
   // ADDIWB  | write result to rt
   // JUMP    | load jump target
   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = STATE_W'(0),
      S_DECODE = STATE_W'(1),
      S_MEMADR = STATE_W'(2),
      S_MEMRD  = STATE_W'(3),
      S_MEMWB  = STATE_W'(4),
      S_MEMWR  = STATE_W'(5),
      S_EXEC   = STATE_W'(6),
      S_ALUWB  = STATE_W'(7),
      S_BRANCH = STATE_W'(8),
      S_ADDIEX = STATE_W'(9),
      S_ADDIWB = STATE_W'(10),
      S_JUMP   = STATE_W'(11)
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   state_t state_q, state_d;

   logic       mem_req_c, iord_c, mem_write_c, ir_write_c, reg_dst_c, mem_to_reg_c;
   logic       reg_write_c, alu_src_a_c, pc_en_c, illegal_c, retire_c;
   logic [1:0] alu_src_b_c, pc_src_c;
   logic [2:0] alu_control_c;
   logic       funct_ok;
   logic [2:0] funct_alu;

   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = 3'd2;
      case (funct)
         6'b100000: funct_alu = 3'd2;
         6'b100010: funct_alu = 3'd3;
         6'b100100: funct_alu = 3'd0;
         6'b100101: funct_alu = 3'd1;
         6'b101010: funct_alu = 3'd6;
         6'b000100: funct_alu = 3'd4;
         6'b000110: funct_alu = 3'd5;
         default:   funct_ok  = 1'b0;
      endcase
   end

   always_comb begin
      state_d       = S_FETCH;
      mem_req_c     = 1'b0;
      iord_c        = 1'b0;
      mem_write_c   = 1'b0;
      ir_write_c    = 1'b0;
      reg_dst_c     = 1'b0;
      mem_to_reg_c  = 1'b0;
      reg_write_c   = 1'b0;
      alu_src_a_c   = 1'b0;
      alu_src_b_c   = 2'b00;
      alu_control_c = 3'd2;
      pc_src_c      = 2'b00;
      pc_en_c       = 1'b0;
      illegal_c     = 1'b0;
      retire_c      = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req_c   = 1'b1;
            alu_src_b_c = 2'b01;
            ir_write_c  = mem_ready;
            pc_en_c     = mem_ready;
            state_d     = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_b_c = 2'b11;
            if (op == OP_LW || op == OP_SW)          state_d = S_MEMADR;
            else if (op == RTYPE_OP && funct_ok)     state_d = S_EXEC;
            else if (op == OP_BEQ || op == OP_BNE)   state_d = S_BRANCH;
            else if (op == OP_ADDI)                  state_d = S_ADDIEX;
            else if (op == OP_J)                     state_d = S_JUMP;
            else                                     illegal_c = 1'b1;
         end
         S_MEMADR: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'b10;
            state_d     = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_req_c = 1'b1;
            iord_c    = 1'b1;
            state_d   = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            mem_to_reg_c = 1'b1;
            reg_write_c  = 1'b1;
            retire_c     = 1'b1;
         end
         S_MEMWR: begin
            mem_req_c   = 1'b1;
            iord_c      = 1'b1;
            mem_write_c = 1'b1;
            retire_c    = mem_ready;
            state_d     = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_EXEC: begin
            alu_src_a_c   = 1'b1;
            alu_control_c = funct_alu;
            state_d       = S_ALUWB;
         end
         S_ALUWB: begin
            reg_dst_c   = 1'b1;
            reg_write_c = 1'b1;
            retire_c    = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_c   = 1'b1;
            alu_control_c = 3'd3;
            pc_src_c      = 2'b01;
            pc_en_c       = (op == OP_BEQ) ? zero : ~zero;
            retire_c      = 1'b1;
         end
         S_ADDIEX: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'b10;
            state_d     = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write_c = 1'b1;
            retire_c    = 1'b1;
         end
         S_JUMP: begin
            pc_src_c = 2'b10;
            pc_en_c  = 1'b1;
            retire_c = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Strobes are gated by rst_n so nothing fires while the FSM sits in FETCH under reset.
   assign mem_req       = mem_req_c   & rst_n;
   assign mem_write     = mem_write_c & rst_n;
   assign ir_write      = ir_write_c  & rst_n;
   assign reg_write     = reg_write_c & rst_n;
   assign pc_en         = pc_en_c     & rst_n;
   assign illegal_instr = illegal_c   & rst_n;
   assign retire        = retire_c    & rst_n;
   assign iord          = iord_c;
   assign reg_dst       = reg_dst_c;
   assign mem_to_reg    = mem_to_reg_c;
   assign alu_src_a     = alu_src_a_c;
   assign alu_src_b     = alu_src_b_c;
   assign alu_control   = alu_control_c;
   assign pc_src        = pc_src_c;
   assign state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a per-instruction reference model pushes
// expected summaries; a monitor accumulates what the DUT did and compares on retire/illegal.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op, funct;
   logic       zero, mem_ready;
   logic       mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
   logic       alu_src_a, pc_en, illegal_instr, retire;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_control;
   logic [3:0] state;

   multicycle_ctrl #(.STATE_W(4), .RTYPE_OP(6'b000000)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
      .pc_src(pc_src), .pc_en(pc_en), .illegal_instr(illegal_instr), .retire(retire),
      .state(state)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      bit          ill;
      int          cyc;
      logic [63:0] path;
      int          n_freq, n_ir, n_pcf, n_dreq, n_mw, n_rw, n_pce;
      bit          wr_dst, wr_m2r;
      int          pcs, alu;
   } exp_t;

   exp_t expq[$];

   // Reference: what one whole instruction should look like, from the instruction set rules.
   function automatic exp_t model(input logic [5:0] o, input logic [5:0] fn, input bit z,
                                  input int f, input int m);
      exp_t e;
      int   ralu;
      bit   taken;
      ralu = -1;
      case (fn)
         6'h20: ralu = 2;  6'h22: ralu = 3;  6'h24: ralu = 0;  6'h25: ralu = 1;
         6'h2A: ralu = 6;  6'h04: ralu = 4;  6'h06: ralu = 5;
         default: ralu = -1;
      endcase
      e = '{ill: 0, cyc: 0, path: 64'h0, n_freq: f + 1, n_ir: 1, n_pcf: 1, n_dreq: 0,
            n_mw: 0, n_rw: 0, n_pce: 0, wr_dst: 0, wr_m2r: 0, pcs: 0, alu: 2};
      if (o == 6'h23) begin
         e.cyc = 5 + f + m; e.path = 64'h01234; e.n_dreq = m + 1; e.n_rw = 1; e.wr_m2r = 1;
      end else if (o == 6'h2B) begin
         e.cyc = 4 + f + m; e.path = 64'h0125; e.n_dreq = m + 1; e.n_mw = m + 1;
      end else if (o == 6'h00 && ralu >= 0) begin
         e.cyc = 4 + f; e.path = 64'h0167; e.n_rw = 1; e.wr_dst = 1; e.alu = ralu;
      end else if (o == 6'h04 || o == 6'h05) begin
         taken = (o == 6'h04) ? z : !z;
         e.cyc = 3 + f; e.path = 64'h018; e.alu = 3;
         e.n_pce = taken ? 1 : 0; e.pcs = taken ? 1 : 0;
      end else if (o == 6'h08) begin
         e.cyc = 4 + f; e.path = 64'h019A; e.n_rw = 1;
      end else if (o == 6'h02) begin
         e.cyc = 3 + f; e.path = 64'h01B; e.n_pce = 1; e.pcs = 2;
      end else begin
         e.ill = 1; e.cyc = 2 + f; e.path = 64'h01;
      end
      return e;
   endfunction

   // Monitor: accumulate observed behaviour of the current instruction.
   bit          active = 0, fresh = 1;
   int          a_cyc, a_freq, a_ir, a_pcf, a_dreq, a_mw, a_rw, a_pce, a_pcs, a_alu;
   bit          a_dst, a_m2r;
   logic [63:0] a_path;
   logic [3:0]  a_last;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         active = 0; fresh = 1;
      end else begin
         if (!active && fresh && state == 4'd0) begin
            active = 1; fresh = 0;
            a_cyc = 0; a_freq = 0; a_ir = 0; a_pcf = 0; a_dreq = 0; a_mw = 0; a_rw = 0;
            a_pce = 0; a_pcs = 0; a_alu = 2; a_dst = 0; a_m2r = 0; a_path = 64'h0; a_last = 4'd0;
         end
         if (active) begin
            a_cyc++;
            if (state != a_last) begin a_path = {a_path[59:0], state}; a_last = state; end
            if (mem_req && !iord) a_freq++;
            if (mem_req && iord)  a_dreq++;
            if (ir_write)  a_ir++;
            if (mem_write) a_mw++;
            if (reg_write) begin a_rw++; a_dst = reg_dst; a_m2r = mem_to_reg; end
            if (pc_en && state == 4'd0) a_pcf++;
            if (pc_en && state != 4'd0) begin a_pce++; a_pcs = pc_src; end
            if (state == 4'd6 || state == 4'd8) a_alu = alu_control;
            if (retire || illegal_instr) begin
               chk("retire_xor_illegal", retire ^ illegal_instr, 1);
               if (expq.size() == 0) chk("unexpected_completion", 1, 0);
               else begin
                  e = expq.pop_front();
                  chk("kind_illegal", illegal_instr, e.ill);
                  chk("cycles", a_cyc, e.cyc);
                  chk("state_path", int'(a_path[31:0]), int'(e.path[31:0]));
                  chk("fetch_req_cycles", a_freq, e.n_freq);
                  chk("ir_write_cycles", a_ir, e.n_ir);
                  chk("fetch_pc_en", a_pcf, e.n_pcf);
                  chk("data_req_cycles", a_dreq, e.n_dreq);
                  chk("mem_write_cycles", a_mw, e.n_mw);
                  chk("reg_write_cycles", a_rw, e.n_rw);
                  chk("reg_dst", a_dst, e.wr_dst);
                  chk("mem_to_reg", a_m2r, e.wr_m2r);
                  chk("late_pc_en", a_pce, e.n_pce);
                  chk("late_pc_src", a_pcs, e.pcs);
                  chk("alu_control", a_alu, e.alu);
               end
               active = 0; fresh = 1;
            end
         end
      end
   end

   // Driver: memory model answers after f (fetch) or m (data) wait cycles; mem_ready random elsewhere.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] fn, input bit z,
                            input int f, input int m);
      int   cnt = 0;
      bit   left = 0, done = 0;
      logic [3:0] prev, st;
      expq.push_back(model(o, fn, z, f, m));
      op = o; funct = fn; zero = z;
      prev = state;
      for (int k = 0; k < 400 && !done; k++) begin
         st = state;
         if (left && st == 4'd0) done = 1;
         else begin
            if (st != 4'd0) left = 1;
            if (st != prev) cnt = 0;
            prev = st;
            if (st == 4'd0)                     mem_ready = (cnt >= f);
            else if (st == 4'd3 || st == 4'd5) mem_ready = (cnt >= m);
            else                                mem_ready = 1'($urandom_range(0, 1));
            cnt++;
            @(posedge clk); #1;
         end
      end
      chk("instr_done", done, 1);
   endtask

   task automatic reset_during_sw();
      expq.push_back(model(6'h2B, 6'h00, 1'b0, 0, 1000));
      op = 6'h2B; funct = 6'h00; zero = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      for (int k = 0; k < 10 && state != 4'd5; k++) begin @(posedge clk); #1; end
      chk("sw_reached_memwr", state, 5);
      chk("sw_mem_write", mem_write, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_state", state, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_reg_write", reg_write, 0);
      chk("rst_pc_en", pc_en, 0);
      chk("rst_mem_req", mem_req, 0);
      void'(expq.pop_back());
      mem_ready = 1'b1;
      #1;
      chk("rst_ir_write", ir_write, 0);
      chk("rst_pc_en_ready", pc_en, 0);
      @(posedge clk); #1;
      chk("rst_held_state", state, 0);
      rst_n = 1'b1;
      run_instr(6'h00, 6'h20, 1'b0, 1, 0);
   endtask

   logic [5:0] rfun [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h04, 6'h06};

   initial begin
      logic [5:0] o, fn;
      rst_n = 1'b0; op = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", state, 0);
      chk("reset_mem_req", mem_req, 0);
      mem_ready = 1'b1;
      #1;
      chk("reset_ir_write", ir_write, 0);
      chk("reset_pc_en", pc_en, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_instr(6'h00, 6'h20, 1'b0, 0, 0);      // add
      run_instr(6'h23, 6'h00, 1'b0, 0, 3);      // lw, 3 wait cycles
      run_instr(6'h04, 6'h00, 1'b1, 0, 0);      // beq taken
      run_instr(6'h05, 6'h00, 1'b1, 0, 0);      // bne not taken
      run_instr(6'h05, 6'h00, 1'b0, 0, 0);      // bne taken
      for (int i = 0; i < 7; i++) run_instr(6'h00, rfun[i], 1'b0, 0, 0);
      run_instr(6'h00, 6'h3F, 1'b0, 0, 0);      // unsupported funct
      reset_during_sw();
      run_instr(6'h3F, 6'h00, 1'b0, 0, 0);      // unsupported op
      run_instr(6'h02, 6'h00, 1'b0, 0, 0);      // j
      run_instr(6'h08, 6'h00, 1'b0, 2, 0);      // addi with fetch wait
      run_instr(6'h2B, 6'h00, 1'b0, 1, 2);      // sw with waits

      for (int i = 0; i < 150; i++) begin
         fn = rfun[$urandom_range(0, 6)];
         case ($urandom_range(0, 9))
            0: o = 6'h23;
            1: o = 6'h2B;
            2, 3: o = 6'h00;
            4: o = 6'h04;
            5: o = 6'h05;
            6: o = 6'h08;
            7: o = 6'h02;
            8: o = 6'($urandom_range(0, 63));
            default: begin o = 6'h00; fn = 6'($urandom_range(0, 63)); end
         endcase
         run_instr(o, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
      end

      @(negedge clk);
      chk("scoreboard_drained", expq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
